// File: rtl/ysyx_23060136_pipe_skid_reg_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_23060136_DEFINES
// Shared definitions for the elastic pipeline segment register.
//   pipe_state_e : occupancy of the main+skid buffer (EMPTY / ONE / TWO)
//   PC_RST, NOP  : constants used at instantiation sites to compose the
//                  bubble payload (RST_VAL) of a segment register
//   pipe_bubble  : helper packing {PC_RST, NOP} into a 64-bit bubble word
// ----------------------------------------------------------------------------
package ysyx_23060136_DEFINES;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    localparam logic [31:0] PC_RST = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    function automatic logic [63:0] pipe_bubble();
        return {PC_RST, NOP};
    endfunction

endpackage

// File: rtl/ysyx_23060136_pipe_skid_reg_if.sv
// ----------------------------------------------------------------------------
// ysyx_23060136_pipe_skid_reg_if
// Valid/ready handshake bundle around one pipeline segment register.
//   in_valid/in_ready/in_data    : upstream side (producer -> segment)
//   out_valid/out_ready/out_data : downstream side (segment -> consumer)
// Modports:
//   master : the surrounding pipeline (drives in_*, out_ready)
//   slave  : the segment register itself
// ----------------------------------------------------------------------------
interface ysyx_23060136_pipe_skid_reg_if #(
    parameter int DATA_W = 64
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/ysyx_23060136_pipe_skid_reg_sat_counter.sv
// ----------------------------------------------------------------------------
// ysyx_23060136_sat_counter
// Saturating up-counter for performance reporting.
//   clk : clock
//   rst : synchronous active-high clear
//   inc : count this cycle
//   cnt : current count, sticks at all-ones
// ----------------------------------------------------------------------------
module ysyx_23060136_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/ysyx_23060136_pipe_skid_reg.sv
// ----------------------------------------------------------------------------
// ysyx_23060136_pipe_skid_reg
// Elastic pipeline segment register with a 2-entry main+skid buffer.
// Full throughput with out_ready high; in_ready is a pure function of the
// registered occupancy, so it never depends combinationally on out_ready.
// Ports:
//   clk        : clock
//   rst        : synchronous active-high reset (dominates flush_i)
//   flush_i    : drop all buffered entries, present RST_VAL as a bubble
//   bus        : handshake bundle (slave modport)
//   stall_cnt  : saturating count of cycles with out_valid & ~out_ready
//   bubble_cnt : saturating count of cycles with ~out_valid
// ----------------------------------------------------------------------------
module ysyx_23060136_pipe_skid_reg
    import ysyx_23060136_DEFINES::*;
#(
    parameter int                DATA_W  = 64,
    parameter logic [DATA_W-1:0] RST_VAL = '0,
    parameter int                CNT_W   = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush_i,
    ysyx_23060136_pipe_skid_reg_if.slave  bus,
    output logic [CNT_W-1:0]              stall_cnt,
    output logic [CNT_W-1:0]              bubble_cnt
);

    pipe_state_e       r_state;
    pipe_state_e       w_state_nxt;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] w_main_nxt;
    logic [DATA_W-1:0] r_skid;
    logic [DATA_W-1:0] w_skid_nxt;

    logic w_in_ready;
    logic w_out_valid;
    logic w_in_fire;
    logic w_out_fire;

    assign w_in_ready  = (r_state != TWO);
    assign w_out_valid = (r_state != EMPTY);
    assign w_in_fire   = bus.in_valid & w_in_ready;
    assign w_out_fire  = w_out_valid & bus.out_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_main;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush_i) begin
            // An entry accepted this cycle is squashed along with the buffer.
            w_state_nxt = EMPTY;
            w_main_nxt  = RST_VAL;
        end else begin
            unique case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = ONE;
                        w_main_nxt  = bus.in_data;
                    end
                end
                ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_nxt = bus.in_data;
                    end else if (w_in_fire) begin
                        // Downstream stalled: park the new entry behind main.
                        w_state_nxt = TWO;
                        w_skid_nxt  = bus.in_data;
                    end else if (w_out_fire) begin
                        w_state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (w_out_fire) begin
                        w_state_nxt = ONE;
                        w_main_nxt  = r_skid;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                end
            endcase
        end
    end

    // Skid payload is only meaningful in TWO, so it needs no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_main  <= RST_VAL;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    ysyx_23060136_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_out_valid & ~bus.out_ready),
        .cnt (stall_cnt)
    );

    ysyx_23060136_sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .inc (~w_out_valid),
        .cnt (bubble_cnt)
    );

endmodule

// File: doc/ysyx_23060136_pipe_skid_reg.md
# ysyx_23060136_pipe_skid_reg

Parametrised elastic pipeline segment register, the successor to the fixed-field MEM/WB-style segment registers. It carries an opaque payload of `DATA_W` bits between two pipeline stages over a valid/ready handshake. A 2-entry main+skid buffer sustains full throughput while keeping upstream ready registered. Flush injects a bubble, and saturating stall/bubble counters feed performance reporting.

## Interface
- `DATA_W`, 64: payload width in bits, ≥1; callers pack pc/inst/ctrl fields.
- `RST_VAL`, `'0`: value of `out_data` after reset or flush (NOP-encoded bubble).
- `CNT_W`, 32: width of performance counters, ≥1.

- `clk` in 1: single clock, all state on posedge.
- `rst` in 1: synchronous, active-high reset.
- `flush_i` in 1: kill all buffered entries; injects bubble.
- `in_valid` in 1: upstream entry valid.
- `in_ready` out 1: block accepts entry; depends only on registered state.
- `in_data` in DATA_W: upstream payload.
- `out_valid` out 1: downstream entry valid.
- `out_ready` in 1: downstream accepts; replaces `stall` semantics (`out_ready = ~stall`).
- `out_data` out DATA_W: payload of oldest entry.
- `stall_cnt` out CNT_W: cycles with `out_valid & ~out_ready`.
- `bubble_cnt` out CNT_W: cycles with `~out_valid`.

## Operation
- `in_fire = in_valid & in_ready`; `out_fire = out_valid & out_ready`.
- Storage: main register (drives `out_data`/`out_valid`), skid register (holds overflow entry).
- States EMPTY / ONE / TWO; `out_valid = (state != EMPTY)`; `in_ready = (state != TWO)`.
- EMPTY: `in_fire` → ONE, main←in; else stay.
- ONE: `in_fire & out_fire` → ONE, main←in. `in_fire & ~out_fire` → TWO, skid←in. `~in_fire & out_fire` → EMPTY. Else hold.
- TWO: `in_ready=0`. `out_fire` → ONE, main←skid. Else hold.
- Ordering strictly FIFO; no entry duplicated or dropped except by flush.
- `flush_i` (any state): next state EMPTY, main data←`RST_VAL`. An entry presented with `in_fire` the same cycle is discarded. A downstream `out_fire` that cycle still counts as consumed.
- `rst` dominates `flush_i`. Inputs are ignored while `rst` is high.
- Counters increment by 1 per qualifying cycle, saturate at 2^CNT_W−1, are cleared only by `rst`, and do not count during `rst` cycles. Flush does not clear them.
- Payload is never inspected; width-agnostic.

## Timing
- Reset values: `out_valid=0`, `out_data=RST_VAL`, `in_ready=1`, `stall_cnt=0`, `bubble_cnt=0`, state EMPTY, in the cycle after `rst` is sampled.
- Latency: 1 cycle `in_fire` → `out_valid` when EMPTY or draining.
- Throughput: 1 entry/cycle with `out_ready` held high.
- `in_ready` has no combinational path from `out_ready`, `in_valid` or `flush_i`. `out_valid`/`out_data` are register outputs.
- Back-pressure: `in_ready` falls the cycle after the second entry is captured and rises the cycle after skid drains.
- The mid-handshake flush rule above applies even when `out_valid & ~out_ready`. Upstream must re-present squashed entries only if its own flush logic requires it.

## Structure
- Shared package `ysyx_23060136_DEFINES`: state enum `pipe_state_e` {EMPTY, ONE, TWO}. The existing `PC_RST`/`NOP` constants compose `RST_VAL` at instantiation sites.
- Sub-module `ysyx_23060136_sat_counter` (parameter `CNT_W`, inputs `clk`, `rst`, `inc`; output `cnt`), instantiated twice.
- One top module; next-state logic in `always_comb`, registers in a single `always_ff`.

## Test plan
- Reset then idle 5 cycles: `out_valid=0`, `out_data=RST_VAL`, `in_ready=1`, `bubble_cnt=5`.
- Stream 0x1..0x8 with `out_ready=1`: outputs 0x1..0x8 in order, one per cycle, 1-cycle latency, `in_ready` constantly 1.
- Send 0xA, 0xB with `out_ready=0`: state TWO, `in_ready=0` next cycle, `stall_cnt` increments each cycle. Raise `out_ready`: 0xA then 0xB, `in_ready` back to 1 after skid drains.
- In TWO, assert `flush_i` with `in_valid=1` (data 0xC): next cycle `out_valid=0`, `out_data=RST_VAL`; 0xC never appears; counters retained.
- `CNT_W=3`, hold `out_ready=0` with one entry for 10 cycles: `stall_cnt` saturates at 7.
- Assert `rst` while in TWO with `flush_i=1`: next cycle all outputs at reset values, counters 0.
